mem_access_stage: RTL and testbench

//  MEM stage of the 16-bit pipeline, directly downstream of the EX/MEM register. It performs the

---
 rtl/mips_pkg.sv | 12 +
 rtl/mem_wb_reg.sv | 34 +++
 rtl/mem_access_stage.sv | 122 ++++++++++++
 tb/tb_mem_access_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and MEM-stage state encoding for the 16-bit pipeline
package mips_pkg;

    localparam int DW = 16;
    localparam int RW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with synchronous reset and bubble insertion
module mem_wb_reg #(
    parameter int DW = mips_pkg::DW,
    parameter int RW = mips_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bubble_i,
    input  logic [DW-1:0] inst_d,
    input  logic [DW-1:0] wb_data_d,
    input  logic          wr_en_d,
    input  logic [RW-1:0] write_addr_d,
    output logic [DW-1:0] inst_q,
    output logic [DW-1:0] wb_data_q,
    output logic          wr_en_q,
    output logic [RW-1:0] write_addr_q
);

    // A bubble is an all-zero slot so writeback sees a harmless no-op.
    always_ff @(posedge clk) begin
        if (rst || bubble_i) begin
            inst_q       <= '0;
            wb_data_q    <= '0;
            wr_en_q      <= 1'b0;
            write_addr_q <= '0;
        end else begin
            inst_q       <= inst_d;
            wb_data_q    <= wb_data_d;
            wr_en_q      <= wr_en_d;
            write_addr_q <= write_addr_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory req/ack handshake, stall, timeout and MEM/WB update
module mem_access_stage #(
    parameter int DW      = mips_pkg::DW,
    parameter int RW      = mips_pkg::RW,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] inst_in,
    input  logic [DW-1:0] res_in,
    input  logic [DW-1:0] store_data_in,
    input  logic          wr_en_in,
    input  logic          mem_store_in,
    input  logic          wb_mem_select_in,
    input  logic [RW-1:0] write_addr_in,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    output logic          stall,
    input  logic          err_clr,
    output logic          bus_err,
    output logic [DW-1:0] inst_out,
    output logic [DW-1:0] wb_data_out,
    output logic          wr_en_out,
    output logic [RW-1:0] write_addr_out
);

    import mips_pkg::*;

    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;

    logic          mem_op;
    logic          is_load;
    logic          at_limit;
    logic          complete;
    logic          timeout;
    logic          bubble;
    logic [DW-1:0] wb_data_d;

    assign mem_op   = mem_store_in | wb_mem_select_in;
    assign is_load  = wb_mem_select_in & ~mem_store_in;
    assign at_limit = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1));
    assign complete = mem_op & (dmem_ack | at_limit);
    // An ack arriving on the last allowed cycle still counts as a real completion.
    assign timeout  = mem_op & at_limit & ~dmem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        if (err_clr) begin
            bus_err_d = 1'b0;
        end
        if (timeout) begin
            bus_err_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (mem_op && !dmem_ack) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (complete || !mem_op) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        dmem_req  = ~rst & mem_op;
        dmem_we   = mem_store_in;
        stall     = mem_op & ~complete;
        bubble    = mem_op & ~complete;
        wb_data_d = is_load ? (dmem_ack ? dmem_rdata : '0) : res_in;
    end

    assign dmem_addr  = res_in;
    assign dmem_wdata = store_data_in;
    assign bus_err    = bus_err_q;

    mem_wb_reg #(
        .DW (DW),
        .RW (RW)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .bubble_i     (bubble),
        .inst_d       (inst_in),
        .wb_data_d    (wb_data_d),
        .wr_en_d      (wr_en_in),
        .write_addr_d (write_addr_in),
        .inst_q       (inst_out),
        .wb_data_q    (wb_data_out),
        .wr_en_q      (wr_en_out),
        .write_addr_q (write_addr_out)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage with a transaction-level model
module tb_mem_access_stage;

    localparam int DW      = 16;
    localparam int RW      = 3;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] inst_in;
    logic [DW-1:0] res_in;
    logic [DW-1:0] store_data_in;
    logic          wr_en_in;
    logic          mem_store_in;
    logic          wb_mem_select_in;
    logic [RW-1:0] write_addr_in;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic          stall;
    logic          err_clr;
    logic          bus_err;
    logic [DW-1:0] inst_out;
    logic [DW-1:0] wb_data_out;
    logic          wr_en_out;
    logic [RW-1:0] write_addr_out;

    int   n_checks = 0;
    int   n_errors = 0;
    logic err_m;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DW      (DW),
        .RW      (RW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .inst_in          (inst_in),
        .res_in           (res_in),
        .store_data_in    (store_data_in),
        .wr_en_in         (wr_en_in),
        .mem_store_in     (mem_store_in),
        .wb_mem_select_in (wb_mem_select_in),
        .write_addr_in    (write_addr_in),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .stall            (stall),
        .err_clr          (err_clr),
        .bus_err          (bus_err),
        .inst_out         (inst_out),
        .wb_data_out      (wb_data_out),
        .wr_en_out        (wr_en_out),
        .write_addr_out   (write_addr_out)
    );

    // One instruction held in EX/MEM until it completes. The memory answers
    // ack_delay cycles after the first request cycle (0 = same cycle, <0 = never).
    task automatic run_instr(input logic [DW-1:0] inst, input logic [DW-1:0] res,
                             input logic [DW-1:0] sd, input logic we, input logic st,
                             input logic ld, input logic [RW-1:0] wa,
                             input int ack_delay, input string tag);
        logic          mem;
        logic          is_load;
        logic          acked;
        int            k_done;
        logic [DW-1:0] rdata_v;
        logic [DW-1:0] exp_wb;
        logic [35:0]   exp_v;
        logic [35:0]   got_v;
        mem     = st | ld;
        is_load = ld & ~st;
        acked   = mem && ack_delay >= 0 && ack_delay <= TIMEOUT;
        k_done  = !mem ? 0 : (acked ? ack_delay : TIMEOUT);
        rdata_v = DW'($urandom);
        exp_wb  = is_load ? (acked ? rdata_v : '0) : res;
        inst_in = inst; res_in = res; store_data_in = sd; wr_en_in = we;
        mem_store_in = st; wb_mem_select_in = ld; write_addr_in = wa;
        for (int k = 0; k <= k_done; k++) begin
            dmem_ack   = mem ? (acked && k == ack_delay) : 1'($urandom_range(0, 1));
            dmem_rdata = (mem && dmem_ack) ? rdata_v : DW'($urandom);
            @(negedge clk);
            n_checks++;
            if (stall !== (mem && k < k_done)) begin
                n_errors++;
                $display("FAIL %s stall k=%0d: got %b want %b", tag, k, stall, (mem && k < k_done));
            end
            n_checks++;
            if (dmem_req !== mem) begin
                n_errors++;
                $display("FAIL %s dmem_req k=%0d: got %b want %b", tag, k, dmem_req, mem);
            end
            if (mem) begin
                n_checks++;
                if ({dmem_we, dmem_addr, dmem_wdata} !== {st, res, sd}) begin
                    n_errors++;
                    $display("FAIL %s dmem_bus k=%0d: got %h want %h", tag, k,
                             {dmem_we, dmem_addr, dmem_wdata}, {st, res, sd});
                end
            end
            @(posedge clk);
            #1;
            if (k == k_done && mem && !acked) err_m = 1'b1;
            else if (err_clr) err_m = 1'b0;
            exp_v = (k < k_done) ? 36'h0 : {inst, exp_wb, we, wa};
            got_v = {inst_out, wb_data_out, wr_en_out, write_addr_out};
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL %s mem_wb k=%0d: got %h want %h", tag, k, got_v, exp_v);
            end
            n_checks++;
            if (bus_err !== err_m) begin
                n_errors++;
                $display("FAIL %s bus_err k=%0d: got %b want %b", tag, k, bus_err, err_m);
            end
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; err_clr = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        inst_in = 16'h1111; res_in = 16'h0040; store_data_in = 16'h0;
        wr_en_in = 1'b1; mem_store_in = 1'b0; wb_mem_select_in = 1'b1; write_addr_in = 3'd2;
        @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset dmem_req: got %b want 0", dmem_req);
        end
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if ({inst_out, wb_data_out, wr_en_out, write_addr_out, bus_err} !== 37'h0) begin
            n_errors++;
            $display("FAIL reset outputs: got %h want 0",
                     {inst_out, wb_data_out, wr_en_out, write_addr_out, bus_err});
        end
        rst = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic test_alu();
        run_instr(16'hA001, 16'h1234, 16'h5555, 1'b1, 1'b0, 1'b0, 3'd3, 0, "alu");
        n_checks++;
        if ({wb_data_out, wr_en_out, write_addr_out} !== {16'h1234, 1'b1, 3'd3}) begin
            n_errors++;
            $display("FAIL alu_wb: got %h want %h", {wb_data_out, wr_en_out, write_addr_out},
                     {16'h1234, 1'b1, 3'd3});
        end
    endtask

    task automatic test_load_zero_wait();
        inst_in = 16'hB002; res_in = 16'h0040; store_data_in = 16'h0; wr_en_in = 1'b1;
        mem_store_in = 1'b0; wb_mem_select_in = 1'b1; write_addr_in = 3'd5;
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
        @(negedge clk);
        n_checks++;
        if ({stall, dmem_req, dmem_we} !== 3'b010) begin
            n_errors++;
            $display("FAIL load0 handshake: got %b want 010", {stall, dmem_req, dmem_we});
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        n_checks++;
        if (wb_data_out !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL load0 wb_data: got %h want beef", wb_data_out);
        end
    endtask

    task automatic test_store_wait3();
        int stalls = 0;
        inst_in = 16'hC003; res_in = 16'h0010; store_data_in = 16'h00AA; wr_en_in = 1'b0;
        mem_store_in = 1'b1; wb_mem_select_in = 1'b0; write_addr_in = 3'd0;
        for (int k = 0; k < 4; k++) begin
            dmem_ack = (k == 3);
            @(negedge clk);
            if (stall) stalls++;
            n_checks++;
            if (dmem_we !== 1'b1) begin
                n_errors++;
                $display("FAIL store dmem_we k=%0d: got %b want 1", k, dmem_we);
            end
            @(posedge clk); #1;
            if (k < 3) begin
                n_checks++;
                if (inst_out !== 16'h0) begin
                    n_errors++;
                    $display("FAIL store bubble k=%0d: got %h want 0", k, inst_out);
                end
            end
        end
        dmem_ack = 1'b0;
        n_checks++;
        if (stalls != 3) begin
            n_errors++;
            $display("FAIL store stall_count: got %0d want 3", stalls);
        end
        n_checks++;
        if ({inst_out, wb_data_out} !== {16'hC003, 16'h0010}) begin
            n_errors++;
            $display("FAIL store writeback: got %h want %h", {inst_out, wb_data_out}, {16'hC003, 16'h0010});
        end
    endtask

    task automatic test_timeout();
        run_instr(16'hD004, 16'h0080, 16'h0, 1'b1, 1'b0, 1'b1, 3'd6, -1, "timeout");
        n_checks++;
        if ({bus_err, wb_data_out, wr_en_out} !== {1'b1, 16'h0, 1'b1}) begin
            n_errors++;
            $display("FAIL timeout result: got %h want %h", {bus_err, wb_data_out, wr_en_out},
                     {1'b1, 16'h0, 1'b1});
        end
        err_clr = 1'b1;
        run_instr(16'hA005, 16'h0007, 16'h0, 1'b1, 1'b0, 1'b0, 3'd1, 0, "err_clr");
        n_checks++;
        if (bus_err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clr: got %b want 0", bus_err);
        end
        // err_clr held throughout a second timeout: the set must win on the last cycle.
        run_instr(16'hD006, 16'h0090, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4, -1, "set_wins");
        err_clr = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        inst_in = 16'hE007; res_in = 16'h0100; store_data_in = 16'h0; wr_en_in = 1'b1;
        mem_store_in = 1'b0; wb_mem_select_in = 1'b1; write_addr_in = 3'd7; dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_wait dmem_req: got %b want 0", dmem_req);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        err_m = 1'b0;
        n_checks++;
        if ({inst_out, wb_data_out, wr_en_out, write_addr_out, bus_err} !== 37'h0) begin
            n_errors++;
            $display("FAIL rst_wait outputs: got %h want 0",
                     {inst_out, wb_data_out, wr_en_out, write_addr_out, bus_err});
        end
        run_instr(16'hE008, 16'h0102, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2, 5, "after_rst");
    endtask

    task automatic test_back_to_back();
        run_instr(16'hF009, 16'h0200, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1, 0, "b2b_0");
        run_instr(16'hF00A, 16'h0202, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2, 0, "b2b_1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            err_clr = ($urandom_range(0, 3) == 0);
            run_instr(DW'($urandom), DW'($urandom), DW'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), RW'($urandom), d, "random");
        end
        err_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_zero_wait();
        test_store_wait3();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
